// File: rtl/phase_pulse_gen.sv
// Phase-locked square-wave regenerator: follows the reference nin and emits nout
// shifted by a programmable phase, reporting lock and falling back to IDLE on loss.
module phase_pulse_gen #(
  parameter int PW       = 4,
  parameter int DUTY     = 8,
  parameter int LOCK_CNT = 3,
  parameter int MISS_MAX = 2
) (
  input  logic          sclk,
  input  logic          re,
  input  logic          nin,
  input  logic [PW-1:0] phi_in,
  input  logic          phi_wr,
  output logic          phi_ack,
  output logic [PW-1:0] phi_out,
  output logic          nout,
  output logic          locked
);

  localparam int OW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [PW-1:0] CNT_MAX = '1;
  localparam logic [PW-1:0] DUTY_V  = PW'(DUTY);
  localparam logic [OW-1:0] LOCK_V  = OW'(LOCK_CNT);
  localparam logic [MW-1:0] MISS_V  = MW'(MISS_MAX);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [PW-1:0] cnt, cnt_n, phi_n, diff;
  logic [OW-1:0] ontime, ontime_n;
  logic [MW-1:0] miss, miss_n;
  logic          nin_d, ein, wrap, ack_n, nout_n, locked_n;

  assign ein  = nin & ~nin_d;
  assign wrap = (cnt == CNT_MAX);
  assign diff = cnt - phi_out;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    phi_n    = phi_out;
    ontime_n = ontime;
    miss_n   = miss;
    locked_n = locked;
    ack_n    = 1'b0;
    nout_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n    = '0;
        ontime_n = '0;
        miss_n   = '0;
        locked_n = 1'b0;
        if (phi_wr) begin
          phi_n = phi_in;
          ack_n = 1'b1;
        end
        if (ein) state_n = RUN;
      end
      RUN: begin
        cnt_n  = cnt + 1'b1;
        nout_n = (diff < DUTY_V);
        if (ontime == LOCK_V) locked_n = 1'b1;
        if (ein && wrap) begin
          miss_n = '0;
          if (ontime != LOCK_V) ontime_n = ontime + 1'b1;
        end else if (ein) begin
          // an edge away from the period boundary re-aligns the counter
          cnt_n    = '0;
          ontime_n = '0;
          locked_n = 1'b0;
        end else if (wrap) begin
          ontime_n = '0;
          locked_n = 1'b0;
          miss_n   = miss + 1'b1;
          if (miss_n == MISS_V) begin
            state_n = IDLE;
            nout_n  = 1'b0;
          end
        end
        // phase changes only land on the boundary so nout never produces a runt pulse
        if (wrap && phi_wr) begin
          phi_n = phi_in;
          ack_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (re) begin
      state   <= IDLE;
      cnt     <= '0;
      phi_out <= '0;
      ontime  <= '0;
      miss    <= '0;
      nout    <= 1'b0;
      phi_ack <= 1'b0;
      locked  <= 1'b0;
      nin_d   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      phi_out <= phi_n;
      ontime  <= ontime_n;
      miss    <= miss_n;
      nout    <= nout_n;
      phi_ack <= ack_n;
      locked  <= locked_n;
      nin_d   <= nin;
    end
  end

endmodule

// File: tb/tb_phase_pulse_gen.sv
// Bench for phase_pulse_gen: per-cycle scoreboard of a behavioural reference plus
// scenario tasks with hand-derived timing checks.
module tb_phase_pulse_gen;

  localparam int PW = 4, DUTY = 8, LOCK_CNT = 3, MISS_MAX = 2, PER = 16;

  logic          sclk = 1'b0, re = 1'b1, nin = 1'b0, phi_wr = 1'b0;
  logic [PW-1:0] phi_in = '0;
  logic          phi_ack, nout, locked;
  logic [PW-1:0] phi_out;

  int   checks = 0, failures = 0;
  int   cyc = 0, last_rise = -100, nout_rise = -100;
  bit   gen = 1'b0;
  int   nin_pos = 0;
  logic nin_prev = 1'b0, nout_prev = 1'b0;

  phase_pulse_gen #(.PW(PW), .DUTY(DUTY), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)) dut (
    .sclk(sclk), .re(re), .nin(nin), .phi_in(phi_in), .phi_wr(phi_wr),
    .phi_ack(phi_ack), .phi_out(phi_out), .nout(nout), .locked(locked)
  );

  always #5 sclk = ~sclk;

  typedef struct packed {
    logic          nout;
    logic          locked;
    logic          ack;
    logic [PW-1:0] phi;
  } exp_t;

  exp_t exp_q[$];
  int   m_state = 0, m_cnt = 0, m_phi = 0, m_on = 0, m_miss = 0;
  bit   m_nout = 0, m_lock = 0, m_ack = 0, m_nin_d = 0;

  // Reference behaviour: expected registered outputs pushed at each rising edge
  always @(posedge sclk) begin : ref_model
    exp_t x;
    bit   e, bnd;
    int   n_cnt;
    if (re) begin
      m_state = 0; m_cnt = 0; m_phi = 0; m_on = 0; m_miss = 0;
      m_nout = 0; m_lock = 0; m_ack = 0; m_nin_d = 0;
    end else begin
      e     = (nin === 1'b1) && !m_nin_d;
      bnd   = (m_cnt == PER - 1);
      m_ack = 0;
      if (m_state == 0) begin
        m_nout = 0; m_on = 0; m_miss = 0; m_lock = 0; m_cnt = 0;
        if (phi_wr) begin m_phi = int'(phi_in); m_ack = 1; end
        if (e) m_state = 1;
      end else begin
        m_nout = ((((m_cnt - m_phi) % PER) + PER) % PER) < DUTY;
        n_cnt  = (m_cnt + 1) % PER;
        if (m_on == LOCK_CNT) m_lock = 1;
        if (e && bnd) begin
          m_miss = 0;
          if (m_on < LOCK_CNT) m_on++;
        end else if (e) begin
          n_cnt = 0; m_on = 0; m_lock = 0;
        end else if (bnd) begin
          m_on = 0; m_lock = 0; m_miss++;
          if (m_miss >= MISS_MAX) begin m_state = 0; m_nout = 0; end
        end
        if (bnd && phi_wr) begin m_phi = int'(phi_in); m_ack = 1; end
        m_cnt = n_cnt;
      end
      m_nin_d = (nin === 1'b1);
    end
    x.nout = m_nout; x.locked = m_lock; x.ack = m_ack; x.phi = m_phi[PW-1:0];
    exp_q.push_back(x);
  end

  always @(negedge sclk) begin : scoreboard
    exp_t x;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      checks++;
      if (nout !== x.nout) begin failures++; $display("[TB] FAIL sb_nout cyc=%0d got=%b exp=%b", cyc, nout, x.nout); end
      checks++;
      if (locked !== x.locked) begin failures++; $display("[TB] FAIL sb_locked cyc=%0d got=%b exp=%b", cyc, locked, x.locked); end
      checks++;
      if (phi_ack !== x.ack) begin failures++; $display("[TB] FAIL sb_phi_ack cyc=%0d got=%b exp=%b", cyc, phi_ack, x.ack); end
      checks++;
      if (phi_out !== x.phi) begin failures++; $display("[TB] FAIL sb_phi_out cyc=%0d got=%0d exp=%0d", cyc, phi_out, x.phi); end
    end
  end

  // One clock: sample after the edge, emulate the requester, then drive nin for the next cycle
  task automatic tick();
    @(posedge sclk);
    #1;
    cyc++;
    if (phi_wr && phi_ack === 1'b1) phi_wr = 1'b0;
    if (nout === 1'b1 && nout_prev !== 1'b1) nout_rise = cyc;
    nout_prev = nout;
    if (gen) begin
      nin     = (nin_pos < PER / 2);
      nin_pos = (nin_pos + 1) % PER;
    end
    if (nin === 1'b1 && nin_prev !== 1'b1) last_rise = cyc;
    nin_prev = nin;
  endtask

  task automatic test_reset();
    re = 1'b1; nin = 1'b0; phi_wr = 1'b0; gen = 1'b0;
    repeat (3) tick();
    checks++; if (nout !== 1'b0) begin failures++; $display("[TB] FAIL reset_nout got=%b exp=0", nout); end
    checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (phi_ack !== 1'b0) begin failures++; $display("[TB] FAIL reset_phi_ack got=%b exp=0", phi_ack); end
    checks++; if (phi_out !== 4'd0) begin failures++; $display("[TB] FAIL reset_phi_out got=%0d exp=0", phi_out); end
    re = 1'b0;
    tick();
  endtask

  task automatic test_lock();
    int c0;
    gen = 1'b1; nin_pos = 0;
    tick();
    c0 = last_rise;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (cyc == c0 + 49) begin
        checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL lock_early got=%b exp=0", locked); end
      end
      if (cyc == c0 + 50) begin
        checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL lock_set got=%b exp=1", locked); end
      end
      if (nout_rise == cyc) begin
        checks++;
        if (cyc - last_rise != 2) begin failures++; $display("[TB] FAIL nout_rise_lag got=%0d exp=2", cyc - last_rise); end
      end
    end
  endtask

  task automatic test_phase_update();
    int guard, ack_at, highs, rise_k;
    guard = 0;
    while (cyc != last_rise + 8 && guard < 40) begin tick(); guard++; end
    phi_in = 4'd5; phi_wr = 1'b1;
    ack_at = -1; guard = 0;
    while (ack_at < 0 && guard < 40) begin tick(); guard++; if (phi_ack === 1'b1) ack_at = cyc; end
    checks++;
    if (ack_at < 0) begin failures++; $display("[TB] FAIL ack5_timeout got=none exp=ack"); return; end
    checks++; if (ack_at != last_rise + 1) begin failures++; $display("[TB] FAIL ack5_boundary got=%0d exp=%0d", ack_at, last_rise + 1); end
    checks++; if (phi_out !== 4'd5) begin failures++; $display("[TB] FAIL phi5_applied got=%0d exp=5", phi_out); end
    highs = 0; rise_k = -1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) begin
        checks++; if (phi_ack !== 1'b0) begin failures++; $display("[TB] FAIL ack5_single got=%b exp=0", phi_ack); end
      end
      if (nout === 1'b1) highs++;
      if (nout_rise == cyc && rise_k < 0) rise_k = k;
    end
    checks++; if (rise_k != 6) begin failures++; $display("[TB] FAIL phi5_rise got=%0d exp=6", rise_k); end
    checks++; if (highs != DUTY) begin failures++; $display("[TB] FAIL phi5_width got=%0d exp=%0d", highs, DUTY); end
  endtask

  task automatic test_wrap();
    int guard, ack_at, highs;
    guard = 0;
    while (cyc != last_rise + 8 && guard < 40) begin tick(); guard++; end
    phi_in = 4'd12; phi_wr = 1'b1;
    ack_at = -1; guard = 0;
    while (ack_at < 0 && guard < 40) begin tick(); guard++; if (phi_ack === 1'b1) ack_at = cyc; end
    checks++;
    if (ack_at < 0) begin failures++; $display("[TB] FAIL ack12_timeout got=none exp=ack"); return; end
    highs = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (nout === 1'b1) highs++;
      if (k == 4 || k == 13) begin
        checks++; if (nout !== 1'b1) begin failures++; $display("[TB] FAIL wrap_high k=%0d got=%b exp=1", k, nout); end
      end
      if (k == 5 || k == 12) begin
        checks++; if (nout !== 1'b0) begin failures++; $display("[TB] FAIL wrap_low k=%0d got=%b exp=0", k, nout); end
      end
    end
    checks++; if (highs != DUTY) begin failures++; $display("[TB] FAIL wrap_width got=%0d exp=%0d", highs, DUTY); end
  endtask

  task automatic test_shift();
    int guard, prev, r;
    guard = 0;
    while (nin_pos != 12 && guard < 40) begin tick(); guard++; end
    nin_pos = 9;
    prev = last_rise; guard = 0;
    while (last_rise == prev && guard < 40) begin tick(); guard++; end
    checks++;
    if (last_rise == prev) begin failures++; $display("[TB] FAIL shift_timeout got=none exp=rise"); return; end
    r = last_rise;
    checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL shift_lock_drop got=%b exp=0", locked); end
    while (cyc < r + 52) begin
      tick();
      if (cyc == r + 2) begin
        checks++; if (nout !== 1'b1) begin failures++; $display("[TB] FAIL shift_nout_on got=%b exp=1", nout); end
      end
      if (cyc == r + 6) begin
        checks++; if (nout !== 1'b0) begin failures++; $display("[TB] FAIL shift_nout_off got=%b exp=0", nout); end
      end
      if (cyc == r + 49) begin
        checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL shift_relock_early got=%b exp=0", locked); end
      end
      if (cyc == r + 50) begin
        checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL shift_relock got=%b exp=1", locked); end
      end
    end
  endtask

  task automatic test_miss();
    int guard, e0, r;
    guard = 0;
    while (last_rise != cyc && guard < 40) begin tick(); guard++; end
    gen = 1'b0;
    e0 = cyc + 1;
    tick();
    nin = 1'b0;
    while (cyc < e0 + 33) begin
      tick();
      if (cyc == e0 + 20) begin
        checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL miss_unlock got=%b exp=0", locked); end
      end
      if (cyc == e0 + 31) begin
        checks++; if (nout !== 1'b1) begin failures++; $display("[TB] FAIL miss_last_high got=%b exp=1", nout); end
      end
      if (cyc == e0 + 32 || cyc == e0 + 33) begin
        checks++; if (nout !== 1'b0) begin failures++; $display("[TB] FAIL miss_idle_nout got=%b exp=0", nout); end
      end
    end
    phi_in = 4'd3; phi_wr = 1'b1;
    tick();
    checks++; if (phi_ack !== 1'b1) begin failures++; $display("[TB] FAIL idle_ack got=%b exp=1", phi_ack); end
    checks++; if (phi_out !== 4'd3) begin failures++; $display("[TB] FAIL idle_phi got=%0d exp=3", phi_out); end
    tick();
    checks++; if (phi_ack !== 1'b0) begin failures++; $display("[TB] FAIL idle_ack_single got=%b exp=0", phi_ack); end
    gen = 1'b1; nin_pos = 0;
    tick();
    r = last_rise;
    repeat (3) tick();
    checks++; if (nout !== 1'b0 || cyc != r + 3) begin failures++; $display("[TB] FAIL restart_pre got=%b exp=0", nout); end
    tick();
    checks++; if (nout !== 1'b0) begin failures++; $display("[TB] FAIL restart_pre2 got=%b exp=0", nout); end
    tick();
    checks++; if (nout !== 1'b1) begin failures++; $display("[TB] FAIL restart_rise got=%b exp=1", nout); end
    repeat (60) tick();
    checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL restart_relock got=%b exp=1", locked); end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (cyc != last_rise + 6 && guard < 40) begin tick(); guard++; end
    gen = 1'b0;
    phi_in = 4'd7; phi_wr = 1'b1; re = 1'b1;
    tick();
    checks++; if (nout !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_nout got=%b exp=0", nout); end
    checks++; if (phi_out !== 4'd0) begin failures++; $display("[TB] FAIL rst_mid_phi got=%0d exp=0", phi_out); end
    checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_locked got=%b exp=0", locked); end
    checks++; if (phi_ack !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_ack got=%b exp=0", phi_ack); end
    re = 1'b0; phi_wr = 1'b0;
    tick();
    checks++; if (phi_ack !== 1'b0) begin failures++; $display("[TB] FAIL rst_after_ack got=%b exp=0", phi_ack); end
    checks++; if (phi_out !== 4'd0) begin failures++; $display("[TB] FAIL rst_after_phi got=%0d exp=0", phi_out); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_phase_update();
    test_wrap();
    test_shift();
    test_miss();
    test_reset_mid();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
